toggle_sched_arbiter: RTL and testbench



---
 rtl/toggle_sched_arbiter.sv | 109 ++++++++++
 tb/tb_toggle_sched_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_sched_arbiter.sv
// Round-robin arbiter sharing one internal T flip-flop among NUM_REQ requesters.
// The granted requester gets exactly len[i] toggles, or fewer if it drops req early.
module toggle_sched_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     T,
    output logic                     Q,
    output logic [CNT_W-1:0]         toggles_left,
    output logic                     done,
    output logic                     abort
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_owner, r_ptr, w_win, w_ptr_next;
    logic [NUM_REQ-1:0] r_gnt;
    logic [CNT_W-1:0]   r_cnt, w_win_len;
    logic               r_abort, r_q;
    logic               w_found, w_t, w_owner_req;
    int unsigned        w_cand;

    // Search starts at the pointer so the last-served requester ranks lowest.
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_win_len = '0;
        w_cand    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = (32'(r_ptr) + i) % NUM_REQ;
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                w_win     = IDX_W'(w_cand);
                w_win_len = len[w_cand*CNT_W +: CNT_W];
            end
        end
    end

    assign w_owner_req = req[r_owner];
    assign w_t         = (r_state == S_BURST) && w_owner_req;
    assign w_ptr_next  = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        T      = w_t;
        case (r_state)
            S_IDLE:  if (w_found) w_next = (w_win_len != '0) ? S_BURST : S_DONE;
            S_BURST: if (!w_owner_req || r_cnt == CNT_W'(1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            r_q <= r_q ^ w_t;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= NUM_REQ'(1) << w_win;
                        r_owner <= w_win;
                        r_cnt   <= w_win_len;
                        r_abort <= 1'b0;
                    end
                end
                S_BURST: begin
                    // A dropped request freezes the count so software sees what was left.
                    if (!w_owner_req) r_abort <= 1'b1;
                    else              r_cnt   <= r_cnt - 1'b1;
                end
                S_DONE: begin
                    r_gnt   <= '0;
                    r_abort <= 1'b0;
                    r_ptr   <= w_ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign Q            = r_q;
    assign toggles_left = r_cnt;
    assign abort        = r_abort;

endmodule

// File: tb/tb_toggle_sched_arbiter.sv
// Self-checking bench for toggle_sched_arbiter: per-scenario tasks plus a
// scoreboard of expected {gnt, Q, abort} at each done pulse.
module tb_toggle_sched_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    typedef struct {
        logic [N-1:0] gnt;
        logic         q;
        logic         ab;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] len = '0;
    logic [N-1:0]   gnt;
    logic           busy, T, Q, done, abort;
    logic [W-1:0]   toggles_left;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    logic q_model = 1'b0;

    toggle_sched_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .len(len), .gnt(gnt), .busy(busy),
        .T(T), .Q(Q), .toggles_left(toggles_left), .done(done), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt, busy, T, Q, toggles_left, done, abort} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b T=%b Q=%b tl=%0d done=%b abort=%b expected all zero",
                     gnt, busy, T, Q, toggles_left, done, abort);
        end
        rst_n   = 1'b1;
        q_model = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req      = 4'b0001;
        len[0+:W] = 4'd3;
        sb.push_back('{4'b0001, q_model ^ 1'b1, 1'b0});
        q_model ^= 1'b1;
        @(negedge clk);
        n_checks++;
        if ({gnt, busy, T, toggles_left, done} !== {4'b0001, 1'b1, 1'b1, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b busy=%b T=%b tl=%0d done=%b expected 0001 1 1 3 0",
                     gnt, busy, T, toggles_left, done);
        end
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk);
            n_checks++;
            if ({toggles_left, done, T} !== {W'(i), (i == 0), (i != 0)}) begin
                n_fail++;
                $display("FAIL single_count: got tl=%0d done=%b T=%b expected tl=%0d done=%b T=%b",
                         toggles_left, done, T, i, (i == 0), (i != 0));
            end
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL single_sb: got empty scoreboard expected one entry");
        end else begin
            e = sb.pop_front();
            if ({gnt, Q, abort} !== {e.gnt, e.q, e.ab}) begin
                n_fail++;
                $display("FAIL single_done: got gnt=%b Q=%b abort=%b expected %b %b %b",
                         gnt, Q, abort, e.gnt, e.q, e.ab);
            end
        end
        req = '0;
        @(negedge clk);
        n_checks++;
        if ({gnt, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL single_release: got gnt=%b busy=%b done=%b expected 0 0 0", gnt, busy, done);
        end
    endtask

    task automatic test_round_robin();
        int cyc  = 0;
        int last = 0;
        int seen = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        q_model = 1'b0;
        req = 4'b1111;
        len = {N{4'd1}};
        for (int g = 0; g < 5; g++) begin
            sb.push_back('{4'b0001 << (g % N), q_model ^ 1'b1, 1'b0});
            q_model ^= 1'b1;
        end
        for (int c = 0; c < 40 && seen < 5; c++) begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if (!$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL rr_onehot: got gnt=%b expected at most one bit set", gnt);
            end
            if (done) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr_sb: got empty scoreboard expected an entry");
                end else begin
                    e = sb.pop_front();
                    if ({gnt, Q, abort} !== {e.gnt, e.q, e.ab}) begin
                        n_fail++;
                        $display("FAIL rr_done: got gnt=%b Q=%b abort=%b expected %b %b %b",
                                 gnt, Q, abort, e.gnt, e.q, e.ab);
                    end
                end
                if (seen > 0) begin
                    n_checks++;
                    if (cyc - last != 3) begin
                        n_fail++;
                        $display("FAIL rr_spacing: got %0d cycles expected 3", cyc - last);
                    end
                end
                last = cyc;
                seen++;
                if (seen == 5) req = '0;
            end
        end
        n_checks++;
        if (seen != 5) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d done pulses expected 5", seen);
        end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        req = 4'b0100;
        len = '0;
        sb.push_back('{4'b0100, q_model, 1'b0});
        @(negedge clk);
        n_checks++;
        if ({gnt, done, T, busy} !== {4'b0100, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_grant: got gnt=%b done=%b T=%b busy=%b expected 0100 1 0 1", gnt, done, T, busy);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL zero_sb: got empty scoreboard expected an entry");
        end else begin
            e = sb.pop_front();
            if ({gnt, Q, abort} !== {e.gnt, e.q, e.ab}) begin
                n_fail++;
                $display("FAIL zero_done: got gnt=%b Q=%b abort=%b expected %b %b %b",
                         gnt, Q, abort, e.gnt, e.q, e.ab);
            end
        end
        req = '0;
        @(negedge clk);
        n_checks++;
        if ({gnt, T, Q} !== {4'b0000, 1'b0, q_model}) begin
            n_fail++;
            $display("FAIL zero_after: got gnt=%b T=%b Q=%b expected 0000 0 %b", gnt, T, Q, q_model);
        end
    endtask

    task automatic test_abort();
        req       = 4'b0010;
        len[W+:W] = 4'd5;
        sb.push_back('{4'b0010, q_model, 1'b1});
        @(negedge clk);
        n_checks++;
        if ({gnt, toggles_left} !== {4'b0010, 4'd5}) begin
            n_fail++;
            $display("FAIL abort_grant: got gnt=%b tl=%0d expected 0010 5", gnt, toggles_left);
        end
        repeat (2) @(negedge clk);
        req = '0;
        #1;
        n_checks++;
        if ({T, toggles_left, Q} !== {1'b0, 4'd3, q_model}) begin
            n_fail++;
            $display("FAIL abort_drop: got T=%b tl=%0d Q=%b expected 0 3 %b", T, toggles_left, Q, q_model);
        end
        @(negedge clk);
        n_checks++;
        if ({done, toggles_left} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL abort_pulse: got done=%b tl=%0d expected 1 3", done, toggles_left);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL abort_sb: got empty scoreboard expected an entry");
        end else begin
            e = sb.pop_front();
            if ({gnt, Q, abort} !== {e.gnt, e.q, e.ab}) begin
                n_fail++;
                $display("FAIL abort_done: got gnt=%b Q=%b abort=%b expected %b %b %b",
                         gnt, Q, abort, e.gnt, e.q, e.ab);
            end
        end
        req = 4'b1101;
        len = '0;
        sb.push_back('{4'b0100, q_model, 1'b0});
        @(negedge clk);
        n_checks++;
        if ({gnt, busy, abort} !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: got gnt=%b busy=%b abort=%b expected 0 0 0", gnt, busy, abort);
        end
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL abort_next_sb: got empty scoreboard expected an entry");
        end else begin
            e = sb.pop_front();
            if ({gnt, done, Q, abort} !== {e.gnt, 1'b1, e.q, e.ab}) begin
                n_fail++;
                $display("FAIL abort_next: got gnt=%b done=%b Q=%b abort=%b expected %b 1 %b %b",
                         gnt, done, Q, abort, e.gnt, e.q, e.ab);
            end
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int n_tog;
        int got = 0;
        req       = 4'b0001;
        len[0+:W] = 4'd7;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL arst_grant: got gnt=%b expected 0001", gnt);
        end
        n_tog = q_model ? 2 : 1;
        repeat (n_tog) @(negedge clk);
        n_checks++;
        if ({Q, busy, T} !== 3'b111) begin
            n_fail++;
            $display("FAIL arst_pre: got Q=%b busy=%b T=%b expected 1 1 1", Q, busy, T);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, busy, Q, T, toggles_left, done} !== '0) begin
            n_fail++;
            $display("FAIL arst_immediate: got gnt=%b busy=%b Q=%b T=%b tl=%0d done=%b expected all zero",
                     gnt, busy, Q, T, toggles_left, done);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        q_model   = 1'b0;
        req       = 4'b0010;
        len[W+:W] = 4'd2;
        sb.push_back('{4'b0010, 1'b0, 1'b0});
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL arst_regrant: got gnt=%b expected 0010", gnt);
        end
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        n_checks++;
        if (got == 0) begin
            n_fail++;
            $display("FAIL arst_timeout: got no done pulse expected one within 10 cycles");
        end else if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL arst_sb: got empty scoreboard expected an entry");
        end else begin
            e = sb.pop_front();
            if ({gnt, Q, abort} !== {e.gnt, e.q, e.ab}) begin
                n_fail++;
                $display("FAIL arst_done: got gnt=%b Q=%b abort=%b expected %b %b %b",
                         gnt, Q, abort, e.gnt, e.q, e.ab);
            end
        end
        req = '0;
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d leftover entries expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
